instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Initiator side of the instruction-port read interface of the dual-port instruction memory. Generates word addresses and read enables for the I-port, which has one-cycle read latency. Captures the returned words into a 2-entry skid buffer and presents {PC, instruction} to decode over a valid/ready handshake. Supports a single-cycle redirect for branches, jumps and traps that flushes in-flight fetches.

Parameters:
RESET_PC, 32'h8000_0000, fetch byte address after reset; bit 31 is the supervisor bit; bits [1:0] must be 0.

Ports:
Clock  in  1  system clock; all state updates on rising edge
Reset_N  in  1  asynchronous, active-low reset
Redirect_Valid  in  1  load new fetch PC this cycle; kills all older fetches
Redirect_PC  in  32  new fetch byte address; bits [1:0] ignored, treated as 0
Mem_En  out  1  I-port read enable; connects to instruction memory En_I
Mem_Addr  out  29  I-port word address = PC[30:2]; connects to Addr_I
Mem_Data  in  32  I-port read data, valid exactly one cycle after Mem_En; from Data_I
Out_Valid  out  1  Out_Instr and Out_PC hold a valid fetched instruction
Out_Ready  in  1  decode accepts when Out_Valid & Out_Ready
Out_Instr  out  32  fetched instruction word
Out_PC  out  32  byte address of Out_Instr, including supervisor bit 31

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset_N is asynchronous and active-low (already decided).
- State:
  - F_PC: next fetch byte address.
  - Req_Pend / Pend_PC: registered copy of Mem_En and its PC.
  - Buffer: 2-entry FIFO of {PC, instr} with occupancy Count in 0..2.
- Reset values, and values while Reset_N=0:
  - F_PC=RESET_PC, Req_Pend=0, Pend_PC=0, Count=0.
  - Buffer entries are all 0.
  - Out_Valid=0, Out_Instr=0, Out_PC=0.
  - Mem_En=0, Mem_Addr=RESET_PC[30:2].
- First cycle after reset release: Mem_En=1, Mem_Addr=RESET_PC[30:2].
- Dequeue: Deq = Out_Valid & Out_Ready.
- Issue rule:
  - Mem_En = 1 iff (Count + Req_Pend - Deq) < 2.
  - This guarantees a slot for every in-flight response. No response is ever dropped, except by a redirect.
- Address and PC increment:
  - Normal case: Mem_Addr = F_PC[30:2].
  - On issue, F_PC[30:2] increments by 1 modulo 2^29.
  - F_PC[31] is unchanged; F_PC[1:0] stays 0.
  - The 29-bit address wraps from 29'h1FFF_FFFF to 0 with no error.
- Landing: if Req_Pend=1 and no redirect in that cycle, {Pend_PC, Mem_Data} is enqueued at the end of the cycle.
- Latency: Mem_En at cycle t, data enqueued at end of t+1, Out_Valid=1 in cycle t+2.
- Throughput: one instruction per cycle with Out_Ready held high.
- Out_Valid = (Count != 0) & ~Redirect_Valid.
  - The mask is combinational, so no handshake completes in a redirect cycle.
- Out_Instr and Out_PC are driven from the buffer head register. They are held stable while Out_Valid & ~Out_Ready.
- Stall: with Out_Ready low, at most 2 instructions accumulate, then Mem_En=0. Buffer contents and F_PC hold.
- Redirect cycle (Redirect_Valid=1) actions:
  - Clear Count to 0.
  - Discard the landing Mem_Data.
  - Mem_En=1 unconditionally, with Mem_Addr = Redirect_PC[30:2] (combinational bypass).
  - Req_Pend<=1 and Pend_PC<={Redirect_PC[31:2], 2'b00}.
  - F_PC <= Redirect_PC with [30:2] incremented by 1.
- Redirect penalty: the first post-redirect instruction has Out_Valid=1 two cycles after the redirect cycle.
- Back-to-back redirects: only the last one takes effect. Every earlier in-flight response is discarded.
- Redirect with a full buffer or during a stall is always taken; the flush dominates.
- Simultaneous enqueue and dequeue: Count is unchanged and FIFO order is preserved.
- Reset asserted mid-operation: all state returns immediately to reset values. The memory response pending at the next edge is ignored because Req_Pend=0.

Decomposition:
- Shared package kabeta_pkg holds:
  - Constants: INSTR_W=32, IMEM_ADDR_W=29, default RESET_PC.
  - Typedef fetch_entry_t = {pc[31:0], instr[31:0]}.
- Sub-module fetch_skid_buffer: 2-entry FIFO of fetch_entry_t with synchronous flush, enq, deq, count and head outputs.
- Issue logic, PC logic and redirect logic stay in instr_fetch_unit.

Test Plan:
- Reset release with memory model returning Data = word address, Out_Ready=1:
  - Mem_Addr sequence 0,1,2,3 from cycle 1.
  - Out_PC 8000_0000, 8000_0004, 8000_0008 valid from cycle 3, one per cycle.
- Out_Ready low for 5 cycles after the first beat:
  - Mem_En falls within 2 cycles; Count=2.
  - Out_PC stays 8000_0004 throughout.
  - On release the sequence continues 8000_0008 with no gap, duplicate or loss.
- Redirect_Valid with Redirect_PC=0000_0100 while Count=2 and Req_Pend=1:
  - Same cycle: Out_Valid=0, Mem_Addr=29'h40.
  - Two cycles later: Out_PC=0000_0100, then 0000_0104.
  - Older PCs never appear.
- Redirects on two consecutive cycles, to 0000_0200 then 0000_0300: the first valid output is Out_PC=0000_0300.
- F_PC=FFFF_FFFC fetched:
  - Next Mem_Addr = 0.
  - Next Out_PC = 8000_0000, with bit 31 preserved.
- Reset_N pulsed low mid-stream with Count=2:
  - Out_Valid=0 and Mem_En=0 asynchronously.
  - After release, the first Out_PC is RESET_PC.

Source files
------------

// File: rtl/kabeta_pkg.sv
// -----------------------------------------------------------------------------
// kabeta_pkg
// Shared definitions for the instruction fetch path.
//   INSTR_W          : instruction word width
//   IMEM_ADDR_W      : instruction-memory word address width (byte PC[30:2])
//   DEFAULT_RESET_PC : fetch byte address after reset (bit 31 = supervisor)
//   fetch_entry_t    : one fetched instruction together with its byte PC
// -----------------------------------------------------------------------------
package kabeta_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned IMEM_ADDR_W = 29;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : kabeta_pkg

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Two-entry FIFO of fetch_entry_t between the instruction-memory read port and
// decode. The head entry is a dedicated register so the consumer sees a stable
// {pc, instr} for as long as it stalls.
// Ports:
//   i_clock      : clock, rising edge
//   i_reset_n    : asynchronous active-low reset
//   i_flush      : synchronous flush, empties the FIFO (dominates enq/deq)
//   i_enq        : write i_enq_data at the tail
//   i_enq_data   : entry to write
//   i_deq        : pop the head entry
//   o_head       : current head entry
//   o_count      : occupancy, 0..2
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import kabeta_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_flush,
    input  logic         i_enq,
    input  fetch_entry_t i_enq_data,
    input  logic         i_deq,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_head;
    fetch_entry_t r_tail;
    logic [1:0]   r_count;
    logic         w_deq;

    // A pop of an empty FIFO is ignored so the count can never underflow.
    assign w_deq = i_deq & (r_count != 2'd0);

    // NOTE: the two storage entries are reset along with the count because the
    // head drives the outputs directly and must read as zero out of reset; a
    // larger FIFO would normally leave its data array unreset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            // Stale entries stay in place; with count at zero they are invisible.
            r_count <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let r_head take the old r_tail in the
            // same edge that r_tail takes new data, independent of statement order.
            unique case ({i_enq, w_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_enq_data;
                    end else begin
                        r_tail <= i_enq_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: count holds, order is kept.
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_enq_data;
                    end else begin
                        r_head <= i_enq_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule : fetch_skid_buffer

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Initiator on the instruction-memory I-port (one-cycle read latency). Issues
// sequential word reads, lands the returned words in a two-entry skid buffer
// and presents {PC, instruction} to decode over valid/ready. A redirect loads a
// new fetch PC in a single cycle and discards every older in-flight fetch.
// Ports:
//   i_clock          : clock, rising edge
//   i_reset_n        : asynchronous active-low reset
//   i_redirect_valid : load i_redirect_pc this cycle, kill older fetches
//   i_redirect_pc    : new fetch byte address, bits [1:0] ignored
//   o_mem_en         : I-port read enable
//   o_mem_addr       : I-port word address (PC[30:2])
//   i_mem_data       : I-port read data, valid the cycle after o_mem_en
//   o_out_valid      : o_out_instr / o_out_pc hold a fetched instruction
//   i_out_ready      : decode accepts when o_out_valid & i_out_ready
//   o_out_instr      : fetched instruction word
//   o_out_pc         : byte address of o_out_instr, including bit 31
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import kabeta_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_redirect_valid,
    input  logic [31:0]            i_redirect_pc,
    output logic                   o_mem_en,
    output logic [IMEM_ADDR_W-1:0] o_mem_addr,
    input  logic [INSTR_W-1:0]     i_mem_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [INSTR_W-1:0]     o_out_instr,
    output logic [31:0]            o_out_pc
);

    // Fetch PC held as supervisor bit + word address; the byte offset is always 0.
    logic                   r_f_sup;
    logic [IMEM_ADDR_W-1:0] r_f_word;
    logic                   r_req_pend;
    logic [31:0]            r_pend_pc;

    fetch_entry_t w_head;
    fetch_entry_t w_enq_data;
    logic [1:0]   w_count;
    logic [2:0]   w_occ;
    logic         w_redirect;
    logic         w_room;
    logic         w_deq;
    logic         w_enq;
    logic         w_unused_ok;

    // The byte offset of a redirect target carries no information.
    assign w_unused_ok = ^i_redirect_pc[1:0];

    // NOTE: every signal written here gets a value on every path, so no latch is
    // inferred; keep it that way when adding outputs.
    always_comb begin
        // Reset gates the redirect bypass so the port is quiet while in reset.
        w_redirect = i_redirect_valid & i_reset_n;

        // No handshake can complete in a redirect cycle.
        o_out_valid = (w_count != 2'd0) & ~i_redirect_valid;
        w_deq       = o_out_valid & i_out_ready;

        // Occupancy after this edge if nothing new is issued: buffered entries
        // plus the response landing now, minus the one decode takes. Issuing
        // only when this is below 2 reserves a slot for every response.
        w_occ  = {1'b0, w_count} + {2'b00, r_req_pend} - {2'b00, w_deq};
        w_room = (w_occ < 3'd2);

        o_mem_en   = i_reset_n & (w_redirect | w_room);
        o_mem_addr = w_redirect ? i_redirect_pc[30:2] : r_f_word;

        // A redirect throws away the response landing in the same cycle.
        w_enq      = r_req_pend & ~i_redirect_valid;
        w_enq_data = '{pc: r_pend_pc, instr: i_mem_data};
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_f_sup    <= RESET_PC[31];
            r_f_word   <= RESET_PC[30:2];
            r_req_pend <= 1'b0;
            r_pend_pc  <= '0;
        end else if (i_redirect_valid) begin
            // The redirect target itself is fetched this cycle, so the next
            // sequential fetch is the word after it.
            r_req_pend <= 1'b1;
            r_pend_pc  <= {i_redirect_pc[31:2], 2'b00};
            r_f_sup    <= i_redirect_pc[31];
            r_f_word   <= i_redirect_pc[30:2] + 29'd1;
        end else begin
            r_req_pend <= o_mem_en;
            if (o_mem_en) begin
                r_pend_pc <= {r_f_sup, r_f_word, 2'b00};
                // Word address wraps modulo 2^29; the supervisor bit is untouched.
                r_f_word  <= r_f_word + 29'd1;
            end
        end
    end

    fetch_skid_buffer u_skid_buffer (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_redirect_valid),
        .i_enq      (w_enq),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign o_out_instr = w_head.instr;
    assign o_out_pc    = w_head.pc;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. The memory model returns the word
// address as data one cycle after a read enable, so every expected instruction
// follows from its PC. Inputs change 1 ns after the rising edge; outputs are
// sampled 1 ns later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_en;
    logic [28:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
        .i_clock          (clock),
        .i_reset_n        (reset_n),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_mem_en         (mem_en),
        .o_mem_addr       (mem_addr),
        .i_mem_data       (mem_data),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_instr      (out_instr),
        .o_out_pc         (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle-latency memory: data = word address; garbage when not read.
    always @(posedge clock) begin
        if (mem_en) mem_data <= {3'b000, mem_addr};
        else        mem_data <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input-drive point).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " pc"},    out_pc,             pc);
        check({tag, " instr"}, out_instr,          instr);
    endtask

    initial begin
        mem_data       = 32'd0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;

        // ---------------- reset state ----------------
        #3;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst mem_en",    {31'd0, mem_en},    32'd0);
        check("rst mem_addr",  {3'd0, mem_addr},   32'd0);
        check("rst out_pc",    out_pc,             32'd0);
        check("rst out_instr", out_instr,          32'd0);
        tick();
        tick();

        // ---------------- reset release, streaming ----------------
        reset_n = 1'b1;                       // cycle 1
        #1;
        check("c1 mem_en",    {31'd0, mem_en},    32'd1);
        check("c1 mem_addr",  {3'd0, mem_addr},   32'd0);
        check("c1 out_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;                           // cycle 2
        check("c2 mem_addr",  {3'd0, mem_addr},   32'd1);
        check("c2 out_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;                           // cycle 3
        beat("c3", 32'h8000_0000, 32'd0);
        check("c3 mem_addr",  {3'd0, mem_addr},   32'd2);

        // ---------------- stall for 5 cycles ----------------
        tick(); out_ready = 1'b0; #1;         // cycle 4: count 1 + pending 1
        beat("c4", 32'h8000_0004, 32'd1);
        check("c4 mem_addr", {3'd0, mem_addr}, 32'd3);
        check("c4 mem_en",   {31'd0, mem_en},  32'd0);
        for (int i = 5; i <= 8; i++) begin   // buffer full, fetch frozen
            tick(); #1;
            beat($sformatf("stall c%0d", i), 32'h8000_0004, 32'd1);
            check($sformatf("stall c%0d mem_en", i), {31'd0, mem_en}, 32'd0);
        end
        tick(); out_ready = 1'b1; #1;         // cycle 9: release
        beat("c9", 32'h8000_0004, 32'd1);
        check("c9 mem_en",   {31'd0, mem_en},  32'd1);
        check("c9 mem_addr", {3'd0, mem_addr}, 32'd3);
        tick(); #1;
        beat("c10", 32'h8000_0008, 32'd2);
        check("c10 mem_addr", {3'd0, mem_addr}, 32'd4);
        tick(); #1;
        beat("c11", 32'h8000_000C, 32'd3);
        tick(); out_ready = 1'b0; #1;         // cycle 12: fill buffer again
        beat("c12", 32'h8000_0010, 32'd4);
        check("c12 mem_en", {31'd0, mem_en}, 32'd0);

        // ---------------- redirect with a full buffer ----------------
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
        check("rd out_valid", {31'd0, out_valid}, 32'd0);
        check("rd mem_en",    {31'd0, mem_en},    32'd1);
        check("rd mem_addr",  {3'd0, mem_addr},   32'h40);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        check("rd+1 out_valid", {31'd0, out_valid}, 32'd0);
        check("rd+1 mem_addr",  {3'd0, mem_addr},   32'h41);
        tick(); #1;
        beat("rd+2", 32'h0000_0100, 32'h40);
        tick(); #1;
        beat("rd+3", 32'h0000_0104, 32'h41);

        // ---------------- back-to-back redirects ----------------
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        check("bb1 out_valid", {31'd0, out_valid}, 32'd0);
        check("bb1 mem_addr",  {3'd0, mem_addr},   32'h80);
        tick(); redirect_pc = 32'h0000_0300; #1;
        check("bb2 out_valid", {31'd0, out_valid}, 32'd0);
        check("bb2 mem_addr",  {3'd0, mem_addr},   32'hC0);
        tick(); redirect_valid = 1'b0; #1;
        check("bb+1 out_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;
        beat("bb+2", 32'h0000_0300, 32'hC0);
        tick(); #1;
        beat("bb+3", 32'h0000_0304, 32'hC1);

        // ---------------- word address wrap ----------------
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        check("wrap rd mem_addr", {3'd0, mem_addr}, 32'h1FFF_FFFF);
        tick(); redirect_valid = 1'b0; #1;
        check("wrap mem_addr", {3'd0, mem_addr}, 32'd0);
        check("wrap mem_en",   {31'd0, mem_en},  32'd1);
        tick(); #1;
        beat("wrap b0", 32'hFFFF_FFFC, 32'h1FFF_FFFF);
        tick(); #1;
        beat("wrap b1", 32'h8000_0000, 32'd0);

        // ---------------- reset mid-stream with full buffer ----------------
        tick(); out_ready = 1'b0; #1;
        beat("pre-rst", 32'h8000_0004, 32'd1);
        tick(); #1;
        check("full mem_en", {31'd0, mem_en}, 32'd0);
        beat("full", 32'h8000_0004, 32'd1);
        #1; reset_n = 1'b0; #1;               // asynchronous, between edges
        check("arst out_valid", {31'd0, out_valid}, 32'd0);
        check("arst mem_en",    {31'd0, mem_en},    32'd0);
        check("arst mem_addr",  {3'd0, mem_addr},   32'd0);
        check("arst out_pc",    out_pc,             32'd0);
        out_ready = 1'b1;
        tick(); #1;
        check("in rst out_valid", {31'd0, out_valid}, 32'd0);
        tick(); reset_n = 1'b1; #1;
        check("rel mem_en",   {31'd0, mem_en},  32'd1);
        check("rel mem_addr", {3'd0, mem_addr}, 32'd0);
        tick(); #1;
        check("rel+1 out_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;
        beat("rel+2", 32'h8000_0000, 32'd0);
        tick(); #1;
        beat("rel+3", 32'h8000_0004, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
